// File: rtl/hazard_control_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
//   slot_t      : one in-flight producer record {valid, writereg, regdest, isload}
//   REG_ZERO    : hard-wired zero register; never a real dependency
//   STALL_CNT_W : width of the saturating stall counter
package hazard_control_pkg;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         STALL_CNT_W = 16;

  typedef struct packed {
    logic       valid;
    logic       writereg;
    logic [4:0] regdest;
    logic       isload;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{valid: 1'b0, writereg: 1'b0, regdest: REG_ZERO, isload: 1'b0};

endpackage

// File: rtl/hazard_control_match.sv
// Dependency check of one ID source operand against one tracked producer.
// Ports:
//   use_src : ID instruction reads this operand
//   addr    : operand register address
//   slot    : producer record (EX or MEM)
//   hit     : producer will write the register this operand reads
module hazard_match
  import hazard_control_pkg::*;
(
  input  logic       use_src,
  input  logic [4:0] addr,
  input  slot_t      slot,
  output logic       hit
);

  // Writes to the zero register are discarded, so they never create a dependency.
  assign hit = use_src && slot.valid && slot.writereg &&
               (slot.regdest == addr) && (slot.regdest != REG_ZERO);

endmodule

// File: rtl/hazard_control.sv
// ID-stage hazard controller for a 5-stage pipeline with branches resolved in ID.
// Tracks the producers now in EX and MEM, detects load-use and branch operand
// hazards, and drives the pipeline hold / flush / bubble / freeze controls.
// Ports:
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   id_*                : decode-stage instruction description
//   mem_busy            : data memory not ready; whole pipeline freezes
//   pc_hold, ifid_hold  : hold PC and IF/ID register
//   ifid_flush          : squash the IF/ID register (taken redirect)
//   idex_bubble         : load NOP controls into ID/EX
//   pipe_freeze         : freeze ID/EX, EX/MEM, MEM/WB
//   stall_count         : saturating count of hazard-stall cycles
// Output priority: reset > mem_busy freeze > hazard stall > redirect > idle.
// All control outputs are combinational; only the slots and counter are registered.
module hazard_control
  import hazard_control_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic                   id_usesa,
  input  logic                   id_usesb,
  input  logic [4:0]             id_addra,
  input  logic [4:0]             id_addrb,
  input  logic                   id_branch,
  input  logic                   id_taken,
  input  logic                   id_writereg,
  input  logic [4:0]             id_regdest,
  input  logic                   id_readmem,
  input  logic                   mem_busy,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   pipe_freeze,
  output logic [STALL_CNT_W-1:0] stall_count
);

  slot_t                   ex_slot;
  slot_t                   mem_slot;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;

  logic rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
  logic load_use_hazard, branch_hazard, stall;

  hazard_match u_match_rs_ex  (.use_src(id_usesa), .addr(id_addra), .slot(ex_slot),  .hit(rs_ex_hit));
  hazard_match u_match_rt_ex  (.use_src(id_usesb), .addr(id_addrb), .slot(ex_slot),  .hit(rt_ex_hit));
  hazard_match u_match_rs_mem (.use_src(id_usesa), .addr(id_addra), .slot(mem_slot), .hit(rs_mem_hit));
  hazard_match u_match_rt_mem (.use_src(id_usesb), .addr(id_addrb), .slot(mem_slot), .hit(rt_mem_hit));

  // ALU consumers get forwarding from EX/MEM, so only a load one ahead hurts.
  // Branches compare in ID, so any EX producer hurts, and a load in MEM still
  // has no data yet. Hits are ORed so a double dependency is one stall.
  always_comb begin
    load_use_hazard = id_valid && !id_branch &&
                      (rs_ex_hit || rt_ex_hit) && ex_slot.isload;
    branch_hazard   = id_valid && id_branch &&
                      ((rs_ex_hit || rt_ex_hit) ||
                       ((rs_mem_hit || rt_mem_hit) && mem_slot.isload));
    stall           = load_use_hazard || branch_hazard;
  end

  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_freeze = 1'b0;
    if (reset) begin
      // Keep a NOP entering ID/EX while the front end is being cleared.
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      pipe_freeze = 1'b1;
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
    end else if (stall) begin
      // A stalled branch has not really resolved; its redirect is ignored.
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else if (id_valid && id_taken) begin
      ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_slot     <= SLOT_EMPTY;
      mem_slot    <= SLOT_EMPTY;
      stall_cnt_q <= '0;
    end else if (!mem_busy) begin
      mem_slot <= ex_slot;
      if (stall) begin
        ex_slot <= SLOT_EMPTY;
      end else begin
        ex_slot <= '{valid: id_valid, writereg: id_writereg,
                     regdest: id_regdest, isload: id_readmem};
      end
      if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 The port list SHALL be as follows, one port per line (name, direction, width, meaning):
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_usesa  in  1  ID instruction reads the rs operand.
- id_usesb  in  1  ID instruction reads the rt operand.
- id_addra  in  5  rs address (instr[25:21]).
- id_addrb  in  5  rt address (instr[20:16]).
- id_branch  in  1  ID instruction resolves in ID: conditional branch or register jump.
- id_taken  in  1  ID redirect request (PC-source select from decode).
- id_writereg  in  1  ID instruction writes a register.
- id_regdest  in  5  ID destination register.
- id_readmem  in  1  ID instruction is a load.
- mem_busy  in  1  data memory not ready; freeze pipeline.
- pc_hold  out  1  hold PC.
- ifid_hold  out  1  hold IF/ID register.
- ifid_flush  out  1  clear IF/ID register to NOP.
- idex_bubble  out  1  load NOP controls into ID/EX.
- pipe_freeze  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- stall_count  out  16  saturating count of hazard-stall cycles.

Function
REQ-002 Two tracking slots, EX and MEM, SHALL each hold {valid, writereg, regdest[4:0], isload}.
REQ-003 A slot SHALL match a source when: source used; slot valid; slot writereg=1; slot regdest equals the source address; regdest != 0.
REQ-004 Load-use hazard: id_valid=1, id_branch=0, and an rs or rt source matches the EX slot with isload=1.
REQ-005 Branch hazard: id_valid=1, id_branch=1, and either:
- a source matches the EX slot (any writer); or
- a source matches the MEM slot with isload=1.
REQ-006 Resulting stall lengths SHALL be:
- ALU result to branch: 1 bubble.
- Load to branch: 2 bubbles.
- Load to ALU consumer: 1 bubble.
REQ-007 stall = load-use hazard OR branch hazard; all outputs except stall_count SHALL be combinational in the same cycle.
REQ-008 Freeze priority (mem_busy=1) SHALL produce:
- pipe_freeze=1, pc_hold=1, ifid_hold=1, idex_bubble=0, ifid_flush=0.
- Slots and stall_count unchanged.
REQ-009 Stall (mem_busy=0, stall=1) SHALL produce:
- pc_hold=1, ifid_hold=1, idex_bubble=1, ifid_flush=0.
- id_taken ignored.
REQ-010 Redirect (mem_busy=0, stall=0, id_valid=1, id_taken=1) SHALL produce ifid_flush=1 and all hold/bubble outputs 0.
REQ-011 Otherwise all outputs SHALL be 0.
REQ-012 Slot advance on each edge with mem_busy=0:
- MEM <= EX.
- EX <= {id_valid, id_writereg, id_regdest, id_readmem} when stall=0, else invalid.
REQ-013 stall_count SHALL increment on every edge where mem_busy=0 and stall=1, and saturate at 16'hFFFF (no wrap).
REQ-014 A hazard against both slots SHALL be reported as a single stall; counts SHALL not double.

Reset
REQ-015 On an edge with reset=1 the block SHALL clear both slots to invalid and set stall_count=0.
REQ-016 While reset=1 the outputs SHALL be:
- idex_bubble=1.
- pc_hold=0, ifid_hold=0, ifid_flush=0, pipe_freeze=0.
REQ-017 reset SHALL override mem_busy and stall.
REQ-018 An instruction stalled at reset SHALL be forgotten: no residual stall after release.

Structure
REQ-019 A shared package SHALL hold:
- slot record type.
- REG_ZERO = 5'd0.
- STALL_CNT_W = 16.
REQ-020 One sub-module, hazard_match, SHALL compare one source (use, addr) against one slot; it SHALL be instantiated four times (rs/rt x EX/MEM).

Verification
REQ-021 Load $8, then add using $8 as rs -> exactly one cycle with pc_hold=ifid_hold=idex_bubble=1; stall_count=1.
REQ-022 Load $9, then beq on $9 -> two consecutive stall cycles, then no stall; stall_count=2.
REQ-023 Add to $3, then beq on $3 with id_taken=1 -> one stall with ifid_flush=0, then ifid_flush=1 for one cycle.
REQ-024 Load to $0, then a consumer of $0 -> no stall.
REQ-025 Load-use hazard with mem_busy=1 for 3 cycles -> pipe_freeze=1, idex_bubble=0 for 3 cycles, then one stall cycle; stall_count=1.
REQ-026 Force stall_count to 16'hFFFE, then 3 stall cycles -> value 16'hFFFF and holds. Assert reset mid-stall -> slots cleared; next cycle no stall.
